// File: rtl/cache_arbiter.sv
// Shares one physical-memory line port between the I-cache (reads) and the
// D-cache (reads and write-backs), one whole-line transaction at a time.
module cache_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic                  i_pmem_resp,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic                  d_pmem_resp,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic                  pmem_resp,
  input  logic [LINE_WIDTH-1:0] pmem_rdata
);

  // Requester handshake: a request (read/write) is held, with address and
  // wdata stable, until its *_pmem_resp pulses for one cycle; that pulse is
  // the memory's pmem_resp passed straight through to the granted requester.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t state, state_next;
  logic   last_served, last_served_next;  // 0 = I-cache, 1 = D-cache
  logic   d_req;

  assign d_req        = d_pmem_read | d_pmem_write;
  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      last_served <= 1'b0;
    end else begin
      state       <= state_next;
      last_served <= last_served_next;
    end
  end

  always_comb begin
    state_next       = state;
    last_served_next = last_served;
    pmem_read        = 1'b0;
    pmem_write       = 1'b0;
    pmem_address     = '0;
    pmem_wdata       = '0;
    i_pmem_resp      = 1'b0;
    d_pmem_resp      = 1'b0;
    case (state)
      IDLE: begin
        // On a tie the requester not served last wins.
        if (d_req && (!i_pmem_read || !last_served)) state_next = SERVE_D;
        else if (i_pmem_read)                        state_next = SERVE_I;
      end
      SERVE_I: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        if (pmem_resp) begin
          i_pmem_resp      = ~rst;
          last_served_next = 1'b0;
          state_next       = IDLE;
        end
      end
      SERVE_D: begin
        // A simultaneous read+write is illegal; the write takes precedence.
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        if (pmem_resp) begin
          d_pmem_resp      = ~rst;
          last_served_next = 1'b1;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  d_read_write_exclusive: assert property (
    @(posedge clk) disable iff (rst) !(d_pmem_read && d_pmem_write)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// Bench for cache_arbiter: directed scenarios plus randomized traffic checked
// cycle by cycle against a transaction-level owner/round-robin model.
module tb_cache_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_pmem_read;
  logic [AW-1:0] i_pmem_address;
  logic          i_pmem_resp;
  logic [LW-1:0] i_pmem_rdata;
  logic          d_pmem_read;
  logic          d_pmem_write;
  logic [AW-1:0] d_pmem_address;
  logic [LW-1:0] d_pmem_wdata;
  logic          d_pmem_resp;
  logic [LW-1:0] d_pmem_rdata;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_address;
  logic [LW-1:0] pmem_wdata;
  logic          pmem_resp;
  logic [LW-1:0] pmem_rdata;

  cache_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_resp(i_pmem_resp), .i_pmem_rdata(i_pmem_rdata),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_resp(d_pmem_resp), .d_pmem_rdata(d_pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: who is pending, who owns the memory port, who went last.
  bit            i_pend, d_pend, d_wr, last_d;
  logic [1:0]    owner;  // 0 none, 1 I-cache, 2 D-cache
  logic [AW-1:0] i_addr_m, d_addr_m;
  logic [LW-1:0] d_wd_m, rd_val;
  logic [1:0]    grant_q[$];
  logic [1:0]    exp_q[$];

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_total++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic drive_inputs();
    i_pmem_read    = i_pend;
    i_pmem_address = i_addr_m;
    d_pmem_read    = d_pend & !d_wr;
    d_pmem_write   = d_pend & d_wr;
    d_pmem_address = d_addr_m;
    d_pmem_wdata   = d_wd_m;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i_pend = 0; d_pend = 0; d_wr = 0;
    i_addr_m = '0; d_addr_m = '0; d_wd_m = '0;
    drive_inputs();
    pmem_resp = 1'b0;
    pmem_rdata = '0;
    @(negedge clk);
    #1;
    check("rst_pmem_read", pmem_read, 0);
    check("rst_pmem_write", pmem_write, 0);
    check("rst_pmem_address", pmem_address, 0);
    check("rst_pmem_wdata", pmem_wdata, 0);
    check("rst_i_resp", i_pmem_resp, 0);
    check("rst_d_resp", d_pmem_resp, 0);
    owner  = 2'd0;
    last_d = 1'b0;
  endtask

  // One clock of traffic: requesters may raise new requests, memory may
  // respond, then every output is compared against the model.
  task automatic tick(input int raise_pct, input int resp_pct);
    logic          e_rd, e_wr;
    logic [AW-1:0] e_addr;
    logic [LW-1:0] e_wdata;
    @(negedge clk);
    rst = 1'b0;
    if (!i_pend && $urandom_range(99) < raise_pct) begin
      i_pend   = 1;
      i_addr_m = $urandom & 32'hFFFF_FFE0;
    end
    if (!d_pend && $urandom_range(99) < raise_pct) begin
      d_pend   = 1;
      d_wr     = $urandom_range(1);
      d_addr_m = $urandom & 32'hFFFF_FFE0;
      d_wd_m   = rand_line();
    end
    drive_inputs();
    pmem_resp  = ($urandom_range(99) < resp_pct);
    pmem_rdata = rd_val;
    #1;
    e_rd = 0; e_wr = 0; e_addr = '0; e_wdata = '0;
    if (owner == 2'd1) begin
      e_rd = 1; e_addr = i_addr_m;
    end else if (owner == 2'd2) begin
      e_rd = !d_wr; e_wr = d_wr; e_addr = d_addr_m; e_wdata = d_wd_m;
    end
    check("pmem_read", pmem_read, e_rd);
    check("pmem_write", pmem_write, e_wr);
    check("pmem_address", pmem_address, e_addr);
    check("pmem_wdata", pmem_wdata, e_wdata);
    check("i_resp", i_pmem_resp, owner == 2'd1 && pmem_resp);
    check("d_resp", d_pmem_resp, owner == 2'd2 && pmem_resp);
    if (pmem_resp) begin
      check("i_rdata", i_pmem_rdata, rd_val);
      check("d_rdata", d_pmem_rdata, rd_val);
    end
    if (owner != 2'd0 && pmem_resp) begin
      if (owner == 2'd1) i_pend = 0;
      else d_pend = 0;
      last_d = (owner == 2'd2);
      owner  = 2'd0;
    end else if (owner == 2'd0) begin
      if (i_pend && d_pend) owner = last_d ? 2'd1 : 2'd2;
      else if (d_pend)      owner = 2'd2;
      else if (i_pend)      owner = 2'd1;
      if (owner != 2'd0) grant_q.push_back(owner);
    end
  endtask

  task automatic check_grants(input string tag);
    check({tag, "_count"}, grant_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < grant_q.size(); k++)
      check(tag, grant_q[k], exp_q[k]);
    grant_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1;
    rd_val = '0;
    do_reset();

    // I-cache read of line 0x40, memory answers after three serving cycles
    i_pend = 1; i_addr_m = 32'h0000_0040;
    rd_val = {32{8'hA5}};
    tick(0, 0);
    repeat (3) tick(0, 0);
    tick(0, 100);
    tick(0, 0);
    check("i_read_done", i_pend, 0);

    // D-cache write-back
    do_reset();
    d_pend = 1; d_wr = 1; d_addr_m = 32'h0000_1000; d_wd_m = {8{32'hDEAD_BEEF}};
    tick(0, 0);
    tick(0, 0);
    tick(0, 100);
    tick(0, 0);

    // Both held from reset: D wins the first tie, then strict alternation
    do_reset();
    grant_q.delete();
    i_pend = 1; i_addr_m = 32'h80;
    d_pend = 1; d_wr = 0; d_addr_m = 32'h2000; d_wd_m = rand_line();
    repeat (8) begin
      rd_val = rand_line();
      tick(100, 100);
    end
    exp_q = '{2'd2, 2'd1, 2'd2, 2'd1};
    check_grants("tie_order");

    // After an I service a tie goes to D, after that D service to I
    do_reset();
    grant_q.delete();
    i_pend = 1; i_addr_m = 32'h100;
    tick(0, 0); tick(0, 0); tick(0, 100);
    tick(100, 0); tick(100, 100); tick(100, 0); tick(0, 100);
    exp_q = '{2'd1, 2'd2, 2'd1};
    check_grants("rr_after_i");

    // Reset during a D service; the late memory response is spurious
    do_reset();
    d_pend = 1; d_wr = 0; d_addr_m = 32'h3000; d_wd_m = rand_line();
    tick(0, 0); tick(0, 0);
    @(negedge clk);
    rst = 1'b1;
    i_pend = 0; d_pend = 0; owner = 2'd0; last_d = 1'b0;
    rd_val = rand_line();
    tick(0, 100);
    tick(0, 0);

    // Spurious responses while idle with nothing pending
    repeat (4) tick(0, 100);

    // Randomized traffic
    do_reset();
    repeat (600) begin
      rd_val = rand_line();
      tick(40, 35);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
